// File: rtl/csa_tree_pipelined.sv
// Pipelined multi-operand carry-save reduction tree: cascaded 3:2 compressor levels,
// one register stage per level, then a registered carry-propagate add.
module csa_tree_pipelined #(
  parameter int  WIDTH   = 8,
  parameter int  NUM_OPS = 4,
  localparam int OW      = WIDTH + $clog2(NUM_OPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_OPS*WIDTH-1:0] in_ops,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OW-1:0]            out_psum,
  output logic [OW-1:0]            out_sco,
  output logic [OW-1:0]            out_sum
);

  // Number of vectors left after lvl compressor levels.
  function automatic int ops_after(input int lvl);
    int n = NUM_OPS;
    for (int i = 0; i < lvl; i++) n = n - n / 3;
    return n;
  endfunction

  function automatic int num_levels();
    int n = NUM_OPS;
    int l = 0;
    for (int i = 0; i < 16; i++) begin
      if (n > 2) begin
        n = n - n / 3;
        l++;
      end
    end
    return l;
  endfunction

  localparam int L = num_levels();

  if (NUM_OPS < 3 || NUM_OPS > 16) begin : g_bad_num_ops
    $error("csa_tree_pipelined: NUM_OPS must be in 3..16");
  end

  // ld[k]: stage k captures this cycle; ld[L+1] is the output stage.
  logic [L+1:1] ld;

  assign ld[L+1]  = !out_valid || out_ready;
  assign in_ready = ld[1];

  for (genvar i = 0; i <= L; i++) begin : g_stg
    localparam int N = ops_after(i);
    logic [OW-1:0] q [N];
    logic          v;

    if (i == 0) begin : g_src
      always_comb begin
        for (int j = 0; j < N; j++) q[j] = {{(OW-WIDTH){1'b0}}, in_ops[j*WIDTH +: WIDTH]};
      end
      assign v = in_valid;
    end else begin : g_lvl
      localparam int NIN = ops_after(i - 1);
      localparam int NT  = NIN / 3;
      logic [OW-1:0] src [NIN];
      logic [OW-1:0] nxt [N];
      logic          src_v;

      assign src   = g_stg[i-1].q;
      assign src_v = g_stg[i-1].v;

      // NOTE: every always_comb output gets a default first so no path infers a latch.
      always_comb begin
        for (int j = 0; j < N; j++) nxt[j] = '0;
        for (int t = 0; t < NT; t++) begin
          nxt[2*t]   = src[3*t] ^ src[3*t+1] ^ src[3*t+2];
          nxt[2*t+1] = ((src[3*t] & src[3*t+1]) | (src[3*t] & src[3*t+2]) |
                        (src[3*t+1] & src[3*t+2])) << 1;
        end
        for (int j = 3 * NT; j < NIN; j++) nxt[j-NT] = src[j];
      end

      assign ld[i] = !v || ld[i+1];

      // NOTE: sequential state uses non-blocking assignments so all stages shift on the same edge.
      // NOTE: pipeline data registers are cleared on reset too, so outputs read 0 after reset.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v <= 1'b0;
          for (int j = 0; j < N; j++) q[j] <= '0;
        end else if (ld[i]) begin
          v <= src_v;
          q <= nxt;
        end
      end
    end
  end

  // Final level always yields {psum, shifted carry}; resolve them in the output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_psum  <= '0;
      out_sco   <= '0;
      out_sum   <= '0;
    end else if (ld[L+1]) begin
      out_valid <= g_stg[L].v;
      out_psum  <= g_stg[L].q[0];
      out_sco   <= g_stg[L].q[1];
      out_sum   <= g_stg[L].q[0] + g_stg[L].q[1];
    end
  end

endmodule

// File: tb/tb_csa_tree_pipelined.sv
// Directed tests of the 4-operand tree plus a randomized 16-operand run against a sum model.
module tb_csa_tree_pipelined;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 4 x 8-bit instance (L = 2, OW = 10)
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_ops;
  logic [9:0]  out_psum, out_sco, out_sum;

  // 16 x 8-bit instance (L = 6, OW = 12)
  logic         w_in_valid, w_in_ready, w_out_valid, w_out_ready;
  logic [127:0] w_in_ops;
  logic [11:0]  w_out_psum, w_out_sco, w_out_sum;

  int n_vec = 0;
  int n_err = 0;

  csa_tree_pipelined #(.WIDTH(8), .NUM_OPS(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_ops(in_ops),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_psum(out_psum), .out_sco(out_sco), .out_sum(out_sum)
  );

  csa_tree_pipelined #(.WIDTH(8), .NUM_OPS(16)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_ops(w_in_ops),
    .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_psum(w_out_psum), .out_sco(w_out_sco), .out_sum(w_out_sum)
  );

  function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
    logic [7:0] a8, b8, c8, d8;
    a8 = a[7:0]; b8 = b[7:0]; c8 = c[7:0]; d8 = d[7:0];
    return {d8, c8, b8, a8};
  endfunction

  task automatic chk_bit(input string name, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic chk_sum(input string name, input logic [9:0] exp);
    logic [9:0] red;
    red = out_psum + out_sco;
    n_vec++;
    if (out_valid !== 1'b1 || out_sum !== exp) begin
      n_err++;
      $display("FAIL %s: valid=%b sum=%0d expected valid=1 sum=%0d", name, out_valid, out_sum, exp);
    end
    n_vec++;
    if (red !== exp || out_sco[0] !== 1'b0) begin
      n_err++;
      $display("FAIL %s_redundant: psum+sco=%0d sco0=%b expected %0d sco0=0", name, red, out_sco[0], exp);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk_bit("reset_out_valid", out_valid, 1'b0);
    n_vec++;
    if (out_sum !== 10'd0 || out_psum !== 10'd0 || out_sco !== 10'd0) begin
      n_err++;
      $display("FAIL reset_data: sum=%0d psum=%0d sco=%0d expected 0", out_sum, out_psum, out_sco);
    end
    chk_bit("reset_w_out_valid", w_out_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_bit("reset_in_ready", in_ready, 1'b1);
    chk_bit("reset_w_in_ready", w_in_ready, 1'b1);
  endtask

  task automatic test_max_operands;
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_ops = pack4(255, 255, 255, 255);
    #1;
    chk_bit("max_in_ready", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk_bit("max_not_early", out_valid, 1'b0);
    @(negedge clk);
    #1;
    chk_sum("max_sum", 10'h3FC);
    @(negedge clk);
    #1;
    chk_bit("max_single_result", out_valid, 1'b0);
  endtask

  task automatic test_back_to_back;
    logic [31:0] vecs [3];
    logic [9:0]  sums [3];
    vecs[0] = pack4(1, 2, 3, 4);     sums[0] = 10'd10;
    vecs[1] = pack4(10, 20, 30, 40); sums[1] = 10'd100;
    vecs[2] = pack4(0, 0, 0, 0);     sums[2] = 10'd0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_ops = vecs[k];
      #1;
      chk_bit("b2b_in_ready", in_ready, 1'b1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk_sum("b2b_sum", sums[k]);
      @(negedge clk);
      #1;
    end
    chk_bit("b2b_drained", out_valid, 1'b0);
  endtask

  task automatic test_backpressure;
    logic exp_rdy [5];
    exp_rdy[0] = 1'b1; exp_rdy[1] = 1'b1; exp_rdy[2] = 1'b1; exp_rdy[3] = 1'b0; exp_rdy[4] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; in_ops = pack4(k + 1, k + 1, k + 1, k + 1);
      #1;
      chk_bit("bp_in_ready", in_ready, exp_rdy[k]);
    end
    chk_sum("bp_stalled_hold", 10'd4);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk_bit("bp_full_shift_ready", in_ready, 1'b1);
    for (int k = 0; k < 3; k++) begin
      chk_sum("bp_drain", 10'(4 * (k + 1)));
      @(negedge clk);
      #1;
    end
    chk_bit("bp_no_extra", out_valid, 1'b0);
    chk_bit("bp_ready_after", in_ready, 1'b1);
  endtask

  task automatic test_bubble_collapse;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_ops = pack4(2, 2, 2, 2);
    #1;
    chk_bit("bub_first_ready", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1; in_ops = pack4(3, 3, 3, 3);
    #1;
    chk_sum("bub_at_output", 10'd8);
    chk_bit("bub_ready_1", in_ready, 1'b1);
    @(negedge clk);
    in_ops = pack4(4, 4, 4, 4);
    #1;
    chk_bit("bub_ready_2", in_ready, 1'b1);
    @(negedge clk);
    in_ops = pack4(5, 5, 5, 5);
    #1;
    chk_bit("bub_full", in_ready, 1'b0);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk_sum("bub_drain", 10'(8 + 4 * k));
      @(negedge clk);
      #1;
    end
    chk_bit("bub_no_extra", out_valid, 1'b0);
  endtask

  task automatic test_reset_mid;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; in_ops = pack4(k + 1, k + 1, k + 1, k + 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk_bit("rmid_in_flight", out_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk_bit("rmid_out_valid", out_valid, 1'b0);
    n_vec++;
    if (out_sum !== 10'd0 || out_psum !== 10'd0 || out_sco !== 10'd0) begin
      n_err++;
      $display("FAIL rmid_data: sum=%0d psum=%0d sco=%0d expected 0", out_sum, out_psum, out_sco);
    end
    chk_bit("rmid_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_ops = pack4(7, 7, 7, 7);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk_bit("rmid_flushed_1", out_valid, 1'b0);
    @(negedge clk);
    #1;
    chk_bit("rmid_flushed_2", out_valid, 1'b0);
    @(negedge clk);
    #1;
    chk_sum("rmid_new_sum", 10'd28);
    @(negedge clk);
    #1;
    chk_bit("rmid_single", out_valid, 1'b0);
  endtask

  typedef struct {
    logic [11:0] sum;
    int          cyc;
  } exp_t;

  task automatic test_wide_random;
    exp_t        sb [$];
    exp_t        e;
    logic        ev;
    logic [11:0] red;
    int          s;
    w_out_ready = 1'b1;
    for (int c = 0; c < 10008; c++) begin
      @(negedge clk);
      w_in_valid = (c < 10000) && ($urandom_range(3) != 0);
      for (int k = 0; k < 16; k++) w_in_ops[k*8 +: 8] = 8'($urandom);
      #1;
      ev = (sb.size() > 0) && (sb[0].cyc + 7 == c);
      n_vec++;
      if (w_out_valid !== ev) begin
        n_err++;
        $display("FAIL wide_valid: cycle %0d got %b expected %b", c, w_out_valid, ev);
      end
      if (ev) begin
        e = sb.pop_front();
        red = w_out_psum + w_out_sco;
        n_vec++;
        if (w_out_sum !== e.sum || red !== e.sum || w_out_sco[0] !== 1'b0) begin
          n_err++;
          $display("FAIL wide_sum: cycle %0d sum=%0d psum+sco=%0d sco0=%b expected %0d",
                   c, w_out_sum, red, w_out_sco[0], e.sum);
        end
      end
      if (w_in_valid) begin
        n_vec++;
        if (w_in_ready !== 1'b1) begin
          n_err++;
          $display("FAIL wide_in_ready: cycle %0d got %b expected 1", c, w_in_ready);
        end
        s = 0;
        for (int k = 0; k < 16; k++) s += int'(w_in_ops[k*8 +: 8]);
        e.sum = 12'(s);
        e.cyc = c;
        sb.push_back(e);
      end
    end
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL wide_leftover: %0d results never appeared expected 0", sb.size());
    end
    w_in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; in_ops = '0;
    w_in_valid = 1'b0; w_out_ready = 1'b1; w_in_ops = '0;
    test_reset();
    test_max_operands();
    test_back_to_back();
    test_backpressure();
    test_bubble_collapse();
    test_reset_mid();
    test_wide_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/csa_tree_pipelined.md
Name: csa_tree_pipelined

Overview:
- Pipelined multi-operand carry-save reduction tree; generalises the single 3:2 carry-save adder to NUM_OPS operands of WIDTH bits.
- Reduces operands with cascaded 3:2 compressor levels, one register stage per level, then a final carry-propagate add.
- Exposes both redundant (psum/sco) and resolved sum with valid/ready flow control.
- Used by multiplier partial-product reduction and multi-input accumulation paths in the datapath.

Parameters:
- WIDTH, 8, bit width of each input operand.
- NUM_OPS, 4, number of operands; legal range 3..16, elaboration error otherwise.
- OW, WIDTH+$clog2(NUM_OPS), output width (derived localparam, not overridable); sum never overflows OW.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand vector valid.
- in_ready  output  1  block can accept operand vector this cycle.
- in_ops  input  NUM_OPS*WIDTH  packed operands; operand k at [k*WIDTH +: WIDTH], unsigned.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_psum  output  OW  partial sum of final redundant pair.
- out_sco  output  OW  shift-carry of final redundant pair, already shifted left 1 (bit 0 always 0).
- out_sum  output  OW  resolved sum = out_psum + out_sco mod 2^OW.

Behaviour:
- Level count L: start n=NUM_OPS; each level maps n -> n - floor(n/3) (each full triple -> 2 vectors, leftovers pass through, zero-extended to OW); repeat until n=2. NUM_OPS=3 ->L=1, 4->2, 8->4, 16->6.
- Stage i (1..L) = level-i compressors + register bank with valid bit v[i]. Stage L+1 registers the CPA result: out_sum, and out_psum/out_sco from stage L.
- Latency: accepted input appears at outputs exactly L+1 cycles later when never stalled; throughput 1 result/cycle.
- Operands zero-extended to OW before reduction; all arithmetic mod 2^OW; sco bit shifted out of MSB is discarded (cannot be nonzero by OW choice).
- Flow control, per-stage bubble collapse: stage k loads when v[k]==0 or stage k+1 loads; output stage loads when !out_valid || out_ready. in_ready = stage-1 load condition. Transfer on in_valid&&in_ready; stage loads clear v when upstream invalid.
- Stage registers hold value and valid while stalled; out_* stable while out_valid && !out_ready.
- in_ready is combinational from out_ready and valid bits only, never from in_valid (no loop).
- Full pipeline with out_ready=0: in_ready=0 after L+1 accepts; no data lost or duplicated.
- Simultaneous out handshake and full pipeline: in_ready=1 same cycle, whole pipe shifts.
- Reset (any time, including mid-stall): all v[]=0, out_valid=0, out_psum=out_sco=out_sum=0, in_ready=1 while rst deasserted after; in-flight data discarded. Datapath regs clear to 0.
- No internal state beyond pipeline registers; results leave in acceptance order.

Test Plan:
- WIDTH=8, NUM_OPS=4, out_ready=1: ops {255,255,255,255} -> 3 cycles later out_valid=1, out_sum=10'h3FC, out_psum+out_sco=1020, out_sco[0]=0.
- NUM_OPS=4 streaming back-to-back {1,2,3,4},{10,20,30,40},{0,0,0,0} -> sums 10,100,0 on consecutive cycles, latency 3, in_ready held 1.
- Backpressure: out_ready=0, push 5 vectors -> exactly 3 accepted, in_ready=0; raise out_ready -> 3 results in order, no gaps, then in_ready=1.
- Bubble collapse: one vector accepted, out_ready=0, then 2 idle cycles -> vector at output stage, in_ready=1 until pipe full (2 more accepts).
- Reset mid-operation: assert rst with 3 results in flight -> out_valid=0, all outputs 0 immediately; after release first new input {7,7,7,7} returns 28 after 3 cycles.
- NUM_OPS=16, WIDTH=8 random 10k vectors vs reference model -> out_sum matches, latency 7, out_psum+out_sco==out_sum mod 2^12.
